// File: rtl/moddiv_pkg.sv
// Shared defaults for the programmable modulo divider.
package moddiv_pkg;
    localparam int DEFAULT_WIDTH     = 8;
    localparam int DEFAULT_RESET_DIV = 6;
endpackage

// File: rtl/moddiv_shadow.sv
// Holds a requested divisor until the counter can safely switch to it.
// Zero requests are rejected with a load_err pulse.
module moddiv_shadow
    import moddiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_load,
    input  logic [WIDTH-1:0] div_in,
    input  logic             apply_ok,
    output logic             apply,
    output logic [WIDTH-1:0] new_div,
    output logic             load_ack,
    output logic             load_err
);
    logic             pend_valid_q, pend_valid_d;
    logic [WIDTH-1:0] pend_div_q, pend_div_d;
    logic             ack_q, err_q;
    logic             load_ok;

    assign load_ok = div_load && (div_in != '0);

    // A load arriving on the switching edge is applied directly, so the last write wins.
    assign new_div = load_ok ? div_in : pend_div_q;
    assign apply   = (load_ok || pend_valid_q) && apply_ok;

    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_div_d   = pend_div_q;
        if (load_ok) begin
            pend_valid_d = 1'b1;
            pend_div_d   = div_in;
        end
        if (apply) begin
            pend_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_valid_q <= 1'b0;
            pend_div_q   <= '0;
            ack_q        <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_div_q   <= pend_div_d;
            ack_q        <= apply;
            err_q        <= div_load && (div_in == '0);
        end
    end

    assign load_ack = ack_q;
    assign load_err = err_q;
endmodule

// File: rtl/prog_modulo_divider.sv
// Programmable modulo-N counter with tick pulse and toggle output.
// Optional duty output enabled by defining MODDIV_DUTY_EN.
module prog_modulo_divider
    import moddiv_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int RESET_DIV = DEFAULT_RESET_DIV
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] div_in,
    input  logic             div_load,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] div_active,
    output logic             tick,
    output logic             out,
    output logic             load_ack,
    output logic             load_err
`ifdef MODDIV_DUTY_EN
    ,
    output logic             duty
`endif
);
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic             out_q, out_d;
    logic             tick_q, tick_d;
    logic             wrap, apply;
    logic [WIDTH-1:0] new_div;

    assign wrap = en && (count_q == div_q - 1'b1);

    // While disabled there is no wrap to wait for, so a pending divisor switches immediately.
    moddiv_shadow #(.WIDTH(WIDTH)) u_shadow (
        .clk      (clk),
        .reset    (reset),
        .div_load (div_load),
        .div_in   (div_in),
        .apply_ok (wrap || !en),
        .apply    (apply),
        .new_div  (new_div),
        .load_ack (load_ack),
        .load_err (load_err)
    );

    always_comb begin
        count_d = count_q;
        div_d   = div_q;
        out_d   = out_q;
        tick_d  = tick_q;
        if (en) begin
            tick_d = wrap;
            if (wrap) begin
                count_d = '0;
                out_d   = ~out_q;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
        if (apply) begin
            div_d   = new_div;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            div_q   <= WIDTH'(RESET_DIV);
            out_q   <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            div_q   <= div_d;
            out_q   <= out_d;
            tick_q  <= tick_d;
        end
    end

    assign count      = count_q;
    assign div_active = div_q;
    assign out        = out_q;
    assign tick       = tick_q;

`ifdef MODDIV_DUTY_EN
    logic [WIDTH:0] half_q;
    // Ceiling of N/2 so odd divisors are high for the larger half.
    assign half_q = ({1'b0, div_q} + (WIDTH+1)'(1)) >> 1;
    assign duty   = ({1'b0, count_q} < half_q);
`endif
endmodule

// File: doc/prog_modulo_divider.md
PROG_MODULO_DIVIDER -- requirements
Module: prog_modulo_divider

Interface
REQ-001 The block SHALL take parameter WIDTH, default 8: bit width of counter and divisor.
REQ-002 The block SHALL take parameter RESET_DIV, default 6: divisor N loaded at reset; legal range 1..2^WIDTH-1.
REQ-003 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port en  input  1  count enable; when low, all state holds.
REQ-006 The block SHALL have port div_in  input  WIDTH  requested divisor N.
REQ-007 The block SHALL have port div_load  input  1  single-cycle strobe that captures div_in.
REQ-008 The block SHALL have port count  output  WIDTH  current count, range 0..N-1.
REQ-009 The block SHALL have port div_active  output  WIDTH  divisor currently in use.
REQ-010 The block SHALL have port tick  output  1  registered one-cycle pulse following each wrap.
REQ-011 The block SHALL have port out  output  1  registered toggle on each wrap; period 2N enabled cycles.
REQ-012 The block SHALL have port load_ack  output  1  registered one-cycle pulse when a pending divisor becomes active.
REQ-013 The block SHALL have port load_err  output  1  registered one-cycle pulse when div_load carries div_in==0.

Function
REQ-014 With en=1 and count<N-1, count SHALL increment by 1 each cycle.
REQ-015 With en=1 and count==N-1 (wrap), the block SHALL set count to 0, toggle out and set tick=1 in the following cycle.
REQ-016 tick SHALL be 0 in every cycle not immediately following a wrap.
REQ-017 With N==1, count SHALL stay 0, tick SHALL stay high and out SHALL toggle every enabled cycle.
REQ-018 div_load with div_in!=0 SHALL write div_in to a pending register and set a pending flag.
REQ-019 A second div_load before the pending value is applied SHALL overwrite it; last write wins.
REQ-020 div_load with div_in==0 SHALL be rejected: pending state unchanged, load_err=1 next cycle.
REQ-021 With en=1, a pending divisor SHALL be applied only at a wrap: div_active takes the new value, count restarts at 0, load_ack=1 next cycle.
REQ-022 With en=0, a pending divisor SHALL be applied on the next clock edge: count forced to 0, out unchanged, load_ack=1 next cycle.
REQ-023 When div_load coincides with a wrap, the newly captured value SHALL be applied at that same wrap.
REQ-024 count SHALL never reach or exceed div_active.
REQ-025 With en=0, count, out and tick SHALL hold, except as REQ-022 requires.

Reset
REQ-026 Asserting reset low SHALL immediately set count=0, out=0, tick=0, load_ack=0, load_err=0, pending flag=0 and div_active=RESET_DIV.
REQ-027 Asserting reset mid-count or with a divisor pending SHALL discard the pending divisor.
REQ-028 Counting SHALL resume on the first rising clk edge after reset deasserts.

Configuration
REQ-029 Macro MODDIV_DUTY_EN defined: the block SHALL add output duty, 1 bit, equal to 1 while count < (div_active+1)>>1, else 0.
REQ-030 duty SHALL be decoded from registered state only, with no path from any input.
REQ-031 Macro MODDIV_DUTY_EN undefined: port duty and its logic SHALL be absent; all other behaviour identical.

Structure
REQ-032 Package moddiv_pkg SHALL hold DEFAULT_WIDTH=8 and DEFAULT_RESET_DIV=6.
REQ-033 Sub-module moddiv_shadow SHALL hold the pending register, pending flag, zero check, load_ack and load_err; the counter, out and tick logic SHALL sit in the top level.

Verification
REQ-034 Reset, WIDTH=8, en=1, 24 cycles -> count runs 0..5 repeatedly, tick every 6th cycle, out period 12 cycles.
REQ-035 div_load=1, div_in=3 at count=2 of N=6 -> count continues to 5 then wraps, div_active=3, load_ack one cycle, then count 0,1,2.
REQ-036 div_in=0 with div_load -> load_err one cycle; div_active and counting unchanged.
REQ-037 Load 4, then load 9 before the wrap -> at the wrap div_active=9 and exactly one load_ack pulse.
REQ-038 en=0 at count=3, then div_load=1, div_in=1 -> next edge count=0, div_active=1; with en=1, out toggles every cycle.
REQ-039 reset asserted low at count=4 with a divisor pending -> outputs return to reset values at once; div_active=6 after release.
